// File: rtl/main_fsm_pkg.sv
// Shared multicycle RISC-V controller types: opcodes, FSM states,
// datapath mux encodings and immediate-format selects.
package main_fsm_pkg;

  typedef logic [6:0] opcodetype;

  localparam opcodetype OP_LW  = 7'b0000011;
  localparam opcodetype OP_SW  = 7'b0100011;
  localparam opcodetype OP_R   = 7'b0110011;
  localparam opcodetype OP_I   = 7'b0010011;
  localparam opcodetype OP_JAL = 7'b1101111;
  localparam opcodetype OP_BEQ = 7'b1100011;
  localparam opcodetype OP_LUI = 7'b0110111;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMREAD,
    MEMWB,
    MEMWRITE,
    EXECUTER,
    EXECUTEI,
    ALUWB,
    JAL,
    BEQ,
    LUI
  } statetype;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REGA  = 2'b10;

  localparam logic [1:0] SRCB_WD    = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FN   = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;
  localparam logic [1:0] RES_IMM    = 2'b11;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  typedef struct packed {
    logic       adr_src;
    logic       ir_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] result_src;
    logic       pc_update;
    logic       branch;
    logic       reg_write;
    logic       mem_write;
    logic       instr_done;
  } ctrl_t;

  function automatic logic is_legal(opcodetype o);
    case (o)
      OP_LW, OP_SW, OP_R, OP_I,
      OP_JAL, OP_BEQ, OP_LUI: return 1'b1;
      default:                return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] imm_src_of(opcodetype o);
    case (o)
      OP_SW:   return IMM_S;
      OP_BEQ:  return IMM_B;
      OP_JAL:  return IMM_J;
      OP_LUI:  return IMM_U;
      default: return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/main_fsm_outdec.sv
// Moore output decode: maps the controller state onto the
// datapath control bundle.
module main_fsm_outdec
  import main_fsm_pkg::*;
(
  input  statetype state_i,
  output ctrl_t    ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      FETCH: begin
        ctrl_o.ir_write   = 1'b1;
        ctrl_o.alu_src_a  = SRCA_PC;
        ctrl_o.alu_src_b  = SRCB_FOUR;
        ctrl_o.alu_op     = ALUOP_ADD;
        ctrl_o.result_src = RES_ALURES;
        ctrl_o.pc_update  = 1'b1;
      end
      DECODE: begin
        ctrl_o.alu_src_a = SRCA_OLDPC;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      MEMADR: begin
        ctrl_o.alu_src_a = SRCA_REGA;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      MEMREAD: begin
        ctrl_o.result_src = RES_ALUOUT;
        ctrl_o.adr_src    = 1'b1;
      end
      MEMWB: begin
        ctrl_o.result_src = RES_DATA;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      MEMWRITE: begin
        ctrl_o.result_src = RES_ALUOUT;
        ctrl_o.adr_src    = 1'b1;
        ctrl_o.mem_write  = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      EXECUTER: begin
        ctrl_o.alu_src_a = SRCA_REGA;
        ctrl_o.alu_src_b = SRCB_WD;
        ctrl_o.alu_op    = ALUOP_FN;
      end
      EXECUTEI: begin
        ctrl_o.alu_src_a = SRCA_REGA;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALUOP_FN;
      end
      ALUWB: begin
        ctrl_o.result_src = RES_ALUOUT;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      JAL: begin
        ctrl_o.alu_src_a  = SRCA_OLDPC;
        ctrl_o.alu_src_b  = SRCB_FOUR;
        ctrl_o.alu_op     = ALUOP_ADD;
        ctrl_o.result_src = RES_ALUOUT;
        ctrl_o.pc_update  = 1'b1;
      end
      BEQ: begin
        ctrl_o.alu_src_a  = SRCA_REGA;
        ctrl_o.alu_src_b  = SRCB_WD;
        ctrl_o.alu_op     = ALUOP_SUB;
        ctrl_o.result_src = RES_ALUOUT;
        ctrl_o.branch     = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      LUI: begin
        ctrl_o.result_src = RES_IMM;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/main_fsm.sv
// Multicycle RISC-V main controller: state register, next-state
// logic and the datapath strobe outputs.
module main_fsm
  import main_fsm_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  opcodetype  op,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] ResultSrc,
  output logic       PCUpdate,
  output logic       Branch,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       InstrDone,
  output logic       IllegalOp
);

  statetype state_q;
  statetype state_d;
  ctrl_t    ctrl;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // op is only consulted in DECODE and MEMADR
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R:         state_d = EXECUTER;
          OP_I:         state_d = EXECUTEI;
          OP_JAL:       state_d = JAL;
          OP_BEQ:       state_d = BEQ;
          OP_LUI:       state_d = LUI;
          default:      state_d = FETCH;
        endcase
      end
      MEMADR:   state_d = (op == OP_SW) ? MEMWRITE : MEMREAD;
      MEMREAD:  state_d = MEMWB;
      EXECUTER: state_d = ALUWB;
      EXECUTEI: state_d = ALUWB;
      JAL:      state_d = ALUWB;
      default:  state_d = FETCH;
    endcase
  end

  main_fsm_outdec u_outdec (
    .state_i (state_q),
    .ctrl_o  (ctrl)
  );

  assign AdrSrc    = ctrl.adr_src;
  assign IRWrite   = ctrl.ir_write;
  assign ALUSrcA   = ctrl.alu_src_a;
  assign ALUSrcB   = ctrl.alu_src_b;
  assign ALUOp     = ctrl.alu_op;
  assign ResultSrc = ctrl.result_src;
  assign PCUpdate  = ctrl.pc_update;
  assign Branch    = ctrl.branch;
  assign RegWrite  = ctrl.reg_write;
  assign MemWrite  = ctrl.mem_write;
  assign InstrDone = ctrl.instr_done;
  assign IllegalOp = (state_q == DECODE) && !is_legal(op);

endmodule

// File: tb/tb_main_fsm.sv
// Self-checking bench for main_fsm: opcode table, directed
// corner sequences and a queue-based random reference model.
module tb_main_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] op = 7'd0;
  logic       AdrSrc, IRWrite, PCUpdate, Branch;
  logic       RegWrite, MemWrite, InstrDone, IllegalOp;
  logic [1:0] ALUSrcA, ALUSrcB, ALUOp, ResultSrc;
  logic [15:0] vec;

  int n_chk = 0;
  int n_fail = 0;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] BQ  = 7'b1100011;
  localparam logic [6:0] LU  = 7'b0110111;

  main_fsm dut (
    .clk       (clk),
    .reset     (reset),
    .op        (op),
    .AdrSrc    (AdrSrc),
    .IRWrite   (IRWrite),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ALUOp     (ALUOp),
    .ResultSrc (ResultSrc),
    .PCUpdate  (PCUpdate),
    .Branch    (Branch),
    .RegWrite  (RegWrite),
    .MemWrite  (MemWrite),
    .InstrDone (InstrDone),
    .IllegalOp (IllegalOp)
  );

  always #5 clk = ~clk;

  assign vec = {AdrSrc, IRWrite, ALUSrcA, ALUSrcB, ALUOp, ResultSrc,
                PCUpdate, Branch, RegWrite, MemWrite, InstrDone,
                IllegalOp};

  typedef enum {M_F, M_D, M_MA, M_MR, M_MWB, M_MW,
                M_ER, M_EI, M_AW, M_J, M_B, M_L} mstep_t;

  mstep_t cur = M_F;
  mstep_t pend[$];

  function automatic logic legal(logic [6:0] o);
    return o inside {LW, SW, RT, IT, JL, BQ, LU};
  endfunction

  function automatic logic [15:0] mk(
    logic adr, logic ir, logic [1:0] a, logic [1:0] b,
    logic [1:0] aop, logic [1:0] rs, logic pcu, logic br,
    logic rw, logic mw, logic dn, logic il);
    return {adr, ir, a, b, aop, rs, pcu, br, rw, mw, dn, il};
  endfunction

  // expected control word for each named instruction step
  function automatic logic [15:0] exp_out(mstep_t s, logic [6:0] o);
    case (s)
      M_F:   return mk(0,1,2'b00,2'b10,2'b00,2'b10,1,0,0,0,0,0);
      M_D:   return mk(0,0,2'b01,2'b01,2'b00,2'b00,0,0,0,0,0,!legal(o));
      M_MA:  return mk(0,0,2'b10,2'b01,2'b00,2'b00,0,0,0,0,0,0);
      M_MR:  return mk(1,0,2'b00,2'b00,2'b00,2'b00,0,0,0,0,0,0);
      M_MWB: return mk(0,0,2'b00,2'b00,2'b00,2'b01,0,0,1,0,1,0);
      M_MW:  return mk(1,0,2'b00,2'b00,2'b00,2'b00,0,0,0,1,1,0);
      M_ER:  return mk(0,0,2'b10,2'b00,2'b10,2'b00,0,0,0,0,0,0);
      M_EI:  return mk(0,0,2'b10,2'b01,2'b10,2'b00,0,0,0,0,0,0);
      M_AW:  return mk(0,0,2'b00,2'b00,2'b00,2'b00,0,0,1,0,1,0);
      M_J:   return mk(0,0,2'b01,2'b10,2'b00,2'b00,1,0,0,0,0,0);
      M_B:   return mk(0,0,2'b10,2'b00,2'b01,2'b00,0,1,0,0,1,0);
      default: return mk(0,0,2'b00,2'b00,2'b00,2'b11,0,0,1,0,1,0);
    endcase
  endfunction

  // instruction-level model: decode fills a queue of remaining steps
  task automatic model_edge(input logic [6:0] o);
    if (cur == M_F) begin
      cur = M_D;
    end else begin
      if (cur == M_D) begin
        pend.delete();
        if (o == LW || o == SW) pend = '{M_MA};
        else if (o == RT) pend = '{M_ER, M_AW};
        else if (o == IT) pend = '{M_EI, M_AW};
        else if (o == JL) pend = '{M_J, M_AW};
        else if (o == BQ) pend = '{M_B};
        else if (o == LU) pend = '{M_L};
      end else if (cur == M_MA) begin
        if (o == SW) pend = '{M_MW};
        else pend = '{M_MR, M_MWB};
      end
      if (pend.size() != 0) cur = pend.pop_front();
      else cur = M_F;
    end
  endtask

  task automatic tick;
    @(posedge clk);
    model_edge(op);
    #1;
  endtask

  task automatic chk(input string nm, input logic [15:0] got,
                     input logic [15:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, want);
    end
  endtask

  task automatic chk_int(input string nm, input int got, input int want);
    n_chk++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, want);
    end
  endtask

  task automatic apply_reset(input logic [6:0] o);
    @(negedge clk);
    reset = 1'b1;
    op = o;
    #2;
    chk("reset_state", vec, exp_out(M_F, o));
    @(negedge clk);
    reset = 1'b0;
    cur = M_F;
    pend.delete();
  endtask

  task automatic walk(input string nm, input logic [6:0] o,
                      input mstep_t seq[$]);
    apply_reset(o);
    foreach (seq[i]) begin
      chk($sformatf("%s_c%0d", nm, i + 1), vec, exp_out(seq[i], o));
      tick();
    end
  endtask

  typedef struct {
    string      nm;
    logic [6:0] o;
    int         cyc;
    int         rw;
    int         mw;
    int         dn;
    int         il;
  } vec_t;

  vec_t tbl[9];
  logic [6:0] legs[7];

  initial begin
    tbl[0] = '{"lw",   LU ^ LU ^ LW, 5, 1, 0, 1, 0};
    tbl[1] = '{"sw",   SW, 4, 0, 1, 1, 0};
    tbl[2] = '{"rtype", RT, 4, 1, 0, 1, 0};
    tbl[3] = '{"itype", IT, 4, 1, 0, 1, 0};
    tbl[4] = '{"jal",  JL, 4, 1, 0, 1, 0};
    tbl[5] = '{"beq",  BQ, 3, 0, 1 - 1, 1, 0};
    tbl[6] = '{"lui",  LU, 3, 1, 0, 1, 0};
    tbl[7] = '{"ill7f", 7'h7f, 2, 0, 0, 0, 1};
    tbl[8] = '{"ill00", 7'h00, 2, 0, 0, 0, 1};
    legs = '{LW, SW, RT, IT, JL, BQ, LU};

    #22;

    // per-opcode cycle counts and strobe totals
    foreach (tbl[t]) begin
      int cnt, rw, mw, dn, il;
      cnt = 0; rw = 0; mw = 0; dn = 0; il = 0;
      apply_reset(tbl[t].o);
      do begin
        rw += int'(RegWrite);
        mw += int'(MemWrite);
        dn += int'(InstrDone);
        il += int'(IllegalOp);
        tick();
        cnt++;
      end while (!IRWrite && cnt < 20);
      chk_int({tbl[t].nm, "_cycles"}, cnt, tbl[t].cyc);
      chk_int({tbl[t].nm, "_regwrite"}, rw, tbl[t].rw);
      chk_int({tbl[t].nm, "_memwrite"}, mw, tbl[t].mw);
      chk_int({tbl[t].nm, "_done"}, dn, tbl[t].dn);
      chk_int({tbl[t].nm, "_illegal"}, il, tbl[t].il);
    end

    walk("lw",  LW, '{M_F, M_D, M_MA, M_MR, M_MWB, M_F});
    walk("sw",  SW, '{M_F, M_D, M_MA, M_MW, M_F});
    walk("beq", BQ, '{M_F, M_D, M_B, M_F});
    walk("ill", 7'h7f, '{M_F, M_D, M_F});

    // asynchronous reset in the middle of MEMREAD
    apply_reset(LW);
    tick(); tick(); tick();
    chk("pre_rst_memread", vec, exp_out(M_MR, LW));
    #2;
    reset = 1'b1;
    #1;
    chk("rst_mid_strobes", {13'd0, IRWrite, PCUpdate, AdrSrc}, 16'h6);
    chk("rst_mid_full", vec, exp_out(M_F, LW));
    #2;
    reset = 1'b0;
    cur = M_F;
    pend.delete();
    tick();
    chk("rst_then_decode", vec, exp_out(M_D, LW));

    // back-to-back R, lui, jal
    begin
      int done_at[$];
      logic [6:0] seq3[3];
      int k, prev, got;
      int gaps[3];
      seq3 = '{RT, LU, JL};
      gaps = '{4, 3, 4};
      apply_reset(RT);
      k = 1;
      for (int c = 1; c <= 12; c++) begin
        if (InstrDone) done_at.push_back(c);
        if (IRWrite && c > 1 && k < 3) begin
          op = seq3[k];
          k++;
        end
        tick();
      end
      chk_int("b2b_done_count", done_at.size(), 3);
      prev = 0;
      for (int i = 0; i < 3; i++) begin
        got = (i < done_at.size()) ? done_at[i] - prev : -1;
        if (i < done_at.size()) prev = done_at[i];
        chk_int($sformatf("b2b_gap%0d", i), got, gaps[i]);
      end
    end

    // random opcodes, random async resets, checked against the model
    apply_reset(legs[0]);
    for (int n = 0; n < 2000; n++) begin
      chk($sformatf("rand_%0d", n), vec, exp_out(cur, op));
      chk("rw_mw_excl", {15'd0, RegWrite & MemWrite}, 16'd0);
      if (cur != M_D && cur != M_MA) begin
        if ($urandom_range(1, 0) == 1) op = legs[$urandom_range(6, 0)];
        else op = 7'($urandom);
      end
      if ($urandom_range(99, 0) == 0) begin
        #1;
        reset = 1'b1;
        #1;
        chk("rand_reset", vec, exp_out(M_F, op));
        #1;
        reset = 1'b0;
        cur = M_F;
        pend.delete();
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
